// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared types and encodings for the multicycle ARM control unit
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  // Shared with the extend unit; the encoding must stay in step with it.
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_B   = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // flags are packed {N,Z,C,V}; the never-condition 1111 falls to the default.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v, res;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - condition flag register, condition check and write-enable gating
module cond_logic
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic [1:0] flagw,
  input  logic       pcs,
  input  logic       nextpc,
  input  logic       regw,
  input  logic       memw,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite
);

  logic [3:0] flags;
  logic       condex;

  assign condex = cond_eval(cond, flags);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= 4'b0000;
    end else begin
      if (flagw[1] && condex) flags[3:2] <= aluflags[3:2];
      if (flagw[0] && condex) flags[1:0] <= aluflags[1:0];
    end
  end

  // Enables are held low while reset is asserted so no pending write escapes.
  assign pcwrite  = ~reset & (nextpc | (pcs & condex));
  assign regwrite = ~reset & regw & condex;
  assign memwrite = ~reset & memw & condex;

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle ARM main FSM and decoder
// Optional CMP support (SUB, flags only, no writeback) when CTRL_CMP_EN is defined.
module multicycle_controller
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl
);

  state_t     state, state_next;
  logic [3:0] cmd;
  logic [1:0] alu_dp, flagw_dp, flagw;
  logic       nowrite, nextpc, pcs, regw, memw, irw, rd_pc;

  assign cmd    = Funct[4:1];
  assign rd_pc  = (Rd == 4'hF);
  assign RegSrc = {Op == OP_MEM, Op == OP_B};
  assign IRWrite = irw & ~reset;

  always_comb begin
    case (Op)
      OP_DP:   ImmSrc = IMM_DP;
      OP_MEM:  ImmSrc = IMM_MEM;
      OP_B:    ImmSrc = IMM_B;
      default: ImmSrc = Op;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = S_FETCH;
    case (state)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_MEM:  state_next = S_MEMADR;
          OP_DP:   state_next = Funct[5] ? S_EXECI : S_EXECR;
          OP_B:    state_next = S_BRANCH;
          OP_NOP:  state_next = S_FETCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXECR:  state_next = S_ALUWB;
      S_EXECI:  state_next = S_ALUWB;
      default:  state_next = S_FETCH;
    endcase
  end

  always_comb begin
    alu_dp  = ALU_ADD;
    nowrite = 1'b0;
    case (cmd)
      CMD_ADD: alu_dp = ALU_ADD;
      CMD_SUB: alu_dp = ALU_SUB;
      CMD_AND: alu_dp = ALU_AND;
      CMD_ORR: alu_dp = ALU_ORR;
`ifdef CTRL_CMP_EN
      CMD_CMP: begin
        alu_dp  = ALU_SUB;
        nowrite = 1'b1;
      end
`else
      CMD_CMP: alu_dp = ALU_ADD;
`endif
      default: alu_dp = ALU_ADD;
    endcase
    // Logical ops leave C and V alone.
    if (nowrite)       flagw_dp = 2'b11;
    else if (Funct[0]) flagw_dp = (alu_dp == ALU_AND || alu_dp == ALU_ORR) ? 2'b10 : 2'b11;
    else               flagw_dp = 2'b00;
  end

  always_comb begin
    nextpc     = 1'b0;
    pcs        = 1'b0;
    regw       = 1'b0;
    memw       = 1'b0;
    irw        = 1'b0;
    flagw      = 2'b00;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        nextpc    = 1'b1;
        irw       = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: ALUSrcB = 2'b01;
      S_MEMRD:  AdrSrc  = 1'b1;
      S_MEMWR: begin
        AdrSrc = 1'b1;
        memw   = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        pcs       = rd_pc;
        regw      = ~rd_pc;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_dp;
        flagw      = flagw_dp;
      end
      S_ALUWB: begin
        pcs  = rd_pc;
        regw = ~rd_pc & ~nowrite;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcs       = 1'b1;
      end
      default: ;
    endcase
  end

  cond_logic u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (Cond),
    .aluflags (ALUFlags),
    .flagw    (flagw),
    .pcs      (pcs),
    .nextpc   (nextpc),
    .regw     (regw),
    .memw     (memw),
    .pcwrite  (PCWrite),
    .regwrite (RegWrite),
    .memwrite (MemWrite)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, Rd, ALUFlags;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] M_WE  = 16'hF000;
  localparam logic [15:0] M_ADR = 16'h0800;
  localparam logic [15:0] M_SA  = 16'h0400;
  localparam logic [15:0] M_SB  = 16'h0300;
  localparam logic [15:0] M_RES = 16'h00C0;
  localparam logic [15:0] M_IMM = 16'h0030;
  localparam logic [15:0] M_RS  = 16'h000C;
  localparam logic [15:0] M_AC  = 16'h0003;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
    .ALUFlags(ALUFlags), .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  always #5 clk = ~clk;

  logic [15:0] ctrl;
  assign ctrl = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
                 ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cv(input logic pcw, input logic memw, input logic regw,
                                      input logic irw, input logic adr, input logic sa,
                                      input logic [1:0] sb, input logic [1:0] res,
                                      input logic [1:0] imm, input logic [1:0] rs,
                                      input logic [1:0] ac);
    return {pcw, memw, regw, irw, adr, sa, sb, res, imm, rs, ac};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp, input logic [15:0] mask);
    check(tag, 32'(ctrl & mask), 32'(exp & mask));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_check(input string tag);
    chk({tag, "/fetch"}, cv(1, 0, 0, 1, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00),
        M_WE | M_ADR | M_SA | M_SB | M_RES | M_AC);
  endtask

  task automatic decode_check(input string tag, input logic [1:0] imm, input logic [1:0] rs);
    chk({tag, "/decode"}, cv(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, imm, rs, 2'b00),
        M_WE | M_SA | M_SB | M_RES | M_IMM | M_RS);
  endtask

  task automatic do_mem(input string tag, input logic [3:0] cond, input logic l,
                        input logic [3:0] rd, input logic pass);
    Cond = cond; Op = 2'b01; Funct = {5'b01100, l}; Rd = rd; #1;
    fetch_check(tag);
    step(); decode_check(tag, 2'b01, 2'b10);
    step();
    chk({tag, "/memadr"}, cv(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00),
        M_WE | M_SA | M_SB | M_AC | M_IMM | M_RS);
    step();
    if (l) begin
      chk({tag, "/memrd"}, cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), M_WE | M_ADR);
      step();
      chk({tag, "/memwb"}, cv(pass & (rd == 4'hF), 0, pass & (rd != 4'hF), 0, 0, 0,
          2'b00, 2'b01, 2'b01, 2'b10, 2'b00), M_WE | M_RES | M_IMM);
    end else begin
      chk({tag, "/memwr"}, cv(0, pass, 0, 0, 1, 0, 0, 0, 0, 0, 0), M_WE | M_ADR);
    end
    step();
  endtask

  task automatic do_dp(input string tag, input logic [3:0] cond, input logic [5:0] funct,
                       input logic [3:0] rd, input logic [3:0] alf, input logic pass,
                       input logic [1:0] ac, input logic nowr, input logic [3:0] exp_flags);
    Cond = cond; Op = 2'b00; Funct = funct; Rd = rd; ALUFlags = alf; #1;
    fetch_check(tag);
    step(); decode_check(tag, 2'b00, 2'b00);
    step();
    chk({tag, "/exec"}, cv(0, 0, 0, 0, 0, 0, funct[5] ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b00, ac),
        M_WE | M_SA | M_SB | M_AC | M_IMM | M_RS);
    step();
    chk({tag, "/aluwb"}, cv(pass & (rd == 4'hF), 0, pass & (rd != 4'hF) & ~nowr, 0, 0, 0,
        2'b00, 2'b00, 2'b00, 2'b00, 2'b00), M_WE | M_RES);
    check({tag, "/flags"}, 32'(dut.u_cond.flags), 32'(exp_flags));
    step();
  endtask

  task automatic do_branch(input string tag, input logic [3:0] cond, input logic pass);
    Cond = cond; Op = 2'b10; Funct = 6'b100000; Rd = 4'h0; #1;
    fetch_check(tag);
    step(); decode_check(tag, 2'b10, 2'b01);
    step();
    chk({tag, "/branch"}, cv(pass, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00),
        M_WE | M_SA | M_SB | M_RES | M_IMM | M_RS);
    step();
  endtask

  task automatic sweep(input string tag, input logic [15:0] expv);
    for (int i = 0; i < 16; i++) do_branch($sformatf("%s_c%0d", tag, i), 4'(i), expv[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Cond = 4'hE; Op = 2'b00; Funct = 6'b0; Rd = 4'h0; ALUFlags = 4'h0;
    step(); step();
    chk("reset/outputs", cv(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0),
        M_WE | M_ADR | M_SA | M_SB | M_RES);
    check("reset/flags", 32'(dut.u_cond.flags), 32'h0);
    reset = 1'b0;

    do_mem("ldr", 4'hE, 1'b1, 4'h1, 1'b1);
    do_mem("str", 4'hE, 1'b0, 4'h2, 1'b1);
    do_dp("subs", 4'hE, 6'b000101, 4'h3, 4'b0100, 1'b1, 2'b01, 1'b0, 4'b0100);
    sweep("z", 16'h66A9);
    do_mem("strne", 4'h1, 1'b0, 4'h2, 1'b0);
    do_mem("ldr_pc", 4'hE, 1'b1, 4'hF, 1'b1);
    do_dp("add_pc", 4'hE, 6'b101000, 4'hF, 4'b1111, 1'b1, 2'b00, 1'b0, 4'b0100);
    do_dp("ands", 4'hE, 6'b000001, 4'h2, 4'b1011, 1'b1, 2'b10, 1'b0, 4'b1000);
    do_dp("orr", 4'hE, 6'b011000, 4'h4, 4'b0111, 1'b1, 2'b11, 1'b0, 4'b1000);
    sweep("n", 16'h6A9A);
    do_dp("adds", 4'hE, 6'b101001, 4'h5, 4'b0011, 1'b1, 2'b00, 1'b0, 4'b0011);
    sweep("cv", 16'h6966);
    do_dp("subseq", 4'h0, 6'b000101, 4'h6, 4'b1111, 1'b0, 2'b01, 1'b0, 4'b0011);

    Cond = 4'hE; Op = 2'b11; Funct = 6'b0; Rd = 4'h0; #1;
    fetch_check("nop");
    step(); decode_check("nop", 2'b11, 2'b00);
    step();

`ifdef CTRL_CMP_EN
    do_dp("cmp", 4'hE, 6'b010101, 4'h0, 4'b0110, 1'b1, 2'b01, 1'b1, 4'b0110);
`else
    do_dp("cmp", 4'hE, 6'b010101, 4'h0, 4'b0011, 1'b1, 2'b00, 1'b0, 4'b0011);
`endif

    Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'h1; #1;
    fetch_check("rst");
    step(); step(); step();
    chk("rst/memrd", cv(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), M_WE | M_ADR);
    #3 reset = 1'b1;
    #1 chk("rst/async", cv(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 0, 0, 0),
           M_WE | M_ADR | M_SA | M_SB | M_RES);
    step();
    check("rst/flags", 32'(dut.u_cond.flags), 32'h0);
    chk("rst/held", cv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), M_WE);
    reset = 1'b0; #1;
    do_branch("beq_after_rst", 4'h0, 1'b0);
    fetch_check("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle ARM datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath select. This includes the ImmSrc code for the immediate-extension unit. It also owns the condition-flag register and condition-check logic, and sits between the instruction register and the shared ALU/memory/register-file datapath.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]; 00 DP, 01 MEM, 10 B
- Funct  in  6  Instr[25:20]; [5]=I, [4:1]=cmd, [0]=S (MEM: [0]=L)
- Rd  in  4  Instr[15:12]
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  write enables
- AdrSrc  out  1  0=PC, 1=ALU result
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00 reg B, 01 ExtImm, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALU result
- ImmSrc  out  2  00 DP imm8, 01 MEM imm12, 10 branch imm24
- RegSrc  out  2  [0] read R15 as Rn, [1] Rd as Rm for STR
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- **Transitions:**
  - FETCH → DECODE.
  - DECODE → MEMADR if Op=01.
  - DECODE → EXECI if Op=00 and I=1.
  - DECODE → EXECR if Op=00 and I=0.
  - DECODE → BRANCH if Op=10.
  - DECODE → FETCH if Op=11 (no operation).
  - MEMADR → MEMRD if L=1; MEMADR → MEMWR if L=0.
  - MEMRD → MEMWB.
  - EXECR/EXECI → ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH → FETCH.
- **FETCH:** AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; PC written unconditionally (NextPC).
- **DECODE:** ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (computes PC+8 for R15 reads).
- **MEMADR:** ALUSrcA=0, ALUSrcB=01, ADD.
- **MEMRD and MEMWR:** AdrSrc=1. MEMWR additionally asserts MemWrite.
- **MEMWB:** ResultSrc=01, RegWrite.
- **EXECR:** ALUSrcB=00. **EXECI:** ALUSrcB=01. Both use ALUSrcA=0 and the DP-decoded ALUControl.
- **ALUWB:** ResultSrc=00, RegWrite.
- **BRANCH:** ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCS=1.
- **Static decode:**
  - ImmSrc = Op.
  - RegSrc[0] = (Op=10).
  - RegSrc[1] = (Op=01).
  - DP cmd 0100→ADD, 0010→SUB, 0000→AND, 1100→ORR, any other cmd→ADD.
- **PC-writing writebacks:** PCS=1 in MEMWB/ALUWB when Rd=1111. In that case PCWrite is raised in place of RegWrite.
- **Condition gating:**
  - CondEx from Cond vs stored Flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111→false.
  - PCWrite = NextPC | (PCS & CondEx).
  - RegWrite and MemWrite are FSM value & CondEx.
  - The FSM path is unaffected: a failed instruction still walks all of its states.
- **Flags:** register {N,Z,C,V}. FlagW[1] (NZ) and FlagW[0] (CV) are set for DP with S=1; NZ only for AND/ORR. Update on the clock edge leaving EXECR/EXECI, only when CondEx.

## Timing
- Cycles per instruction:
  - LDR: 5 (FETCH, DECODE, MEMADR, MEMRD, MEMWB).
  - STR: 4.
  - DP: 4.
  - B: 3.
  - Op=11: 2.
- All outputs are Moore functions of state plus registered Flags and IR fields. No output depends combinationally on ALUFlags except the flag-register next value.
- Reset values: state=FETCH, Flags=0000. The first fetch begins on the first edge after reset deasserts.
- Reset asserted mid-instruction: the state returns to FETCH immediately, and any pending write is dropped.
- Instruction fields are sampled from IR, so they are stable from DECODE onward. In FETCH, decode outputs are don't-care apart from the listed controls.

## Configuration
- **CTRL_CMP_EN defined:**
  - cmd 1010 (CMP) decodes to SUB with FlagW=11.
  - RegWrite is suppressed in ALUWB (NoWrite).
- **CTRL_CMP_EN undefined:** cmd 1010 decodes as default ADD with normal writeback.

## Structure
- **Package arm_ctrl_pkg:**
  - state enum.
  - ImmSrc codes: DP=00, MEM=01, B=10, shared with the extend unit.
  - ALUControl codes.
  - Cond code constants.
  - DP cmd constants.
- **One sub-module, cond_logic:**
  - Owns the Flags register and CondEx evaluation.
  - Performs PCWrite/RegWrite/MemWrite gating.
  - The FSM and decoder live in the top module.

## Test plan
- **Reset:** reset pulse mid-MEMRD → state FETCH, all write enables 0, Flags 0000 next cycle.
- **LDR:** LDR R1,[R2,#4] (Op=01, L=1, AL) → exactly 5 states; ImmSrc=01 during MEMADR; RegWrite=1 only in MEMWB.
- **SUBS and BEQ taken:** SUBS R3,R3,R3 then BEQ → Flags Z=1 after EXECR. The branch asserts PCWrite in BRANCH with ImmSrc=10 and RegSrc[0]=1.
- **BNE not taken:** BNE with Z=1 → PCWrite only in FETCH; no write in BRANCH.
- **DP write to PC:** ADD PC,R0,#8 (Rd=1111) → PCWrite=1, RegWrite=0 in ALUWB.
- **CMP with macro:** CMP R1,R1 with CTRL_CMP_EN → ALUControl=01, Z=1, RegWrite=0 in ALUWB. Without the macro → RegWrite=1, Flags unchanged.
